weight_alloc_sequencer: RTL and testbench
=========================================

WEIGHT_ALLOC_SEQUENCER -- requirements
Module: weight_alloc_sequencer

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 8: array rows/cols (N).
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8: bits per weight.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(SYSTOLIC_SIZE): row address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 32: watchdog limit in WAIT.
REQ-005 SHALL have port clk  in  1: single clock, rising edge.
REQ-006 SHALL have port rst_n  in  1: asynchronous active-low reset.
REQ-007 SHALL have port layer_start  in  1: one-cycle request to load a new weight tile.
REQ-008 SHALL have port src_valid  in  1: weight source row valid.
REQ-009 SHALL have port src_ready  out  1: sequencer accepts a row.
REQ-010 SHALL have port src_weights  in  N*WEIGHT_WIDTH: one weight row, row 0 first.
REQ-011 SHALL have port alloc_start  out  1: allocation initialise pulse to the allocation stage.
REQ-012 SHALL have port alloc_weights  out  N*WEIGHT_WIDTH: registered row to the allocation stage.
REQ-013 SHALL have port alloc_weight_valid  out  1: alloc_weights valid, one cycle per row.
REQ-014 SHALL have port recovery_done  in  1: allocation stage done.
REQ-015 SHALL have port recovery_success  in  1: allocation stage mapped all faulty rows.
REQ-016 SHALL have port read_addr  out  ADDR_WIDTH: logical row address for streaming.
REQ-017 SHALL have port stream_valid  out  1: read_addr valid this cycle.
REQ-018 SHALL have port busy  out  1: state is not IDLE.
REQ-019 SHALL have port layer_done  out  1: one-cycle pulse, tile streamed successfully.
REQ-020 SHALL have port layer_fail  out  1: one-cycle pulse, recovery failed or timed out.

Function
REQ-021 SHALL implement states IDLE, START, LOAD, WAIT, STREAM, DONE, FAIL.
REQ-022 IDLE: layer_start=1 -> START; layer_start while not IDLE is ignored.
REQ-023 START: alloc_start=1 for exactly one cycle, row counter cleared to 0, -> LOAD.
REQ-024 LOAD: src_ready=1; each src_valid&&src_ready beat registers src_weights into alloc_weights with alloc_weight_valid=1 in the next cycle (latency 1); src_valid=0 cycles produce alloc_weight_valid=0.
REQ-025 LOAD: row counter increments per accepted beat; after beat N-1 accepted, src_ready drops in the same cycle (combinational from state/counter) and state -> WAIT; no beat beyond N accepted.
REQ-026 recovery_done SHALL be ignored in every state except WAIT (it may assert early during LOAD gaps).
REQ-027 WAIT: entered only after the final alloc_weight_valid cycle; recovery_done=1 and recovery_success=1 -> STREAM; recovery_done=1 and recovery_success=0 -> FAIL.
REQ-028 STREAM: stream_valid=1 for N consecutive cycles with read_addr 0,1,...,N-1, then -> DONE; read_addr SHALL NOT wrap.
REQ-029 DONE: layer_done=1 one cycle -> IDLE. FAIL: layer_fail=1 one cycle -> IDLE.
REQ-030 alloc_weights SHALL hold its last value when alloc_weight_valid=0; read_addr SHALL be 0 outside STREAM.

Reset
REQ-031 rst_n=0 SHALL force IDLE asynchronously; all outputs 0, counters 0, alloc_weights 0, even mid-LOAD or mid-STREAM.
REQ-032 After reset release, first action SHALL require a fresh layer_start.

Configuration
REQ-033 Macro ALLOC_WATCHDOG_EN defined: WAIT counts cycles; reaching TIMEOUT_CYCLES without recovery_done -> FAIL, counter cleared on entry to WAIT.
REQ-034 ALLOC_WATCHDOG_EN undefined: no watchdog counter; WAIT waits indefinitely; TIMEOUT_CYCLES unused.

Structure
REQ-035 State encoding typedef and default parameter constants SHALL live in shared package bisr_pkg.
REQ-036 Single flat module; no sub-module (watchdog is an inline counter).

Verification
REQ-037 N=8: layer_start, src_valid held 1 with rows 1..8 -> alloc_start at cycle 1, alloc_weight_valid cycles 3..10, src_ready low after 8th beat.
REQ-038 src_valid toggling 1/0, recovery_done forced 1 during LOAD -> no WAIT exit before 8th row; recovery_done=1,success=1 in WAIT -> stream_valid 8 cycles, read_addr 0..7, layer_done pulse.
REQ-039 WAIT with recovery_done=1, recovery_success=0 -> layer_fail one cycle, no stream_valid, busy=0 next cycle.
REQ-040 layer_start pulsed during LOAD and STREAM -> ignored, sequence unchanged.
REQ-041 rst_n=0 after 4 rows loaded -> all outputs 0 immediately; new layer_start restarts at row 0 with alloc_start.
REQ-042 ALLOC_WATCHDOG_EN defined, TIMEOUT_CYCLES=32, recovery_done held 0 -> layer_fail at WAIT cycle 32; undefined -> busy stays 1 beyond 100 cycles.

Source files
------------

// File: rtl/bisr_pkg.sv
// ============================================================================
// Module  : bisr_pkg
// Purpose : Shared state encoding and default parameter constants for the
//           weight allocation sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bisr_pkg;

    localparam int DEF_SYSTOLIC_SIZE  = 8;
    localparam int DEF_WEIGHT_WIDTH   = 8;
    localparam int DEF_TIMEOUT_CYCLES = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_STREAM = 3'd4,
        ST_DONE   = 3'd5,
        ST_FAIL   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/weight_alloc_sequencer.sv
// ============================================================================
// Module  : weight_alloc_sequencer
// Purpose : Loads one NxN weight tile into the allocation stage, waits for
//           fault recovery, then streams logical row addresses 0..N-1.
//           Optional WAIT watchdog enabled by macro ALLOC_WATCHDOG_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_alloc_sequencer
    import bisr_pkg::*;
#(
    parameter int SYSTOLIC_SIZE  = DEF_SYSTOLIC_SIZE,
    parameter int WEIGHT_WIDTH   = DEF_WEIGHT_WIDTH,
    parameter int ADDR_WIDTH     = $clog2(SYSTOLIC_SIZE),
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  layer_start,
    input  logic                                  src_valid,
    output logic                                  src_ready,
    input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] src_weights,
    output logic                                  alloc_start,
    output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] alloc_weights,
    output logic                                  alloc_weight_valid,
    input  logic                                  recovery_done,
    input  logic                                  recovery_success,
    output logic [ADDR_WIDTH-1:0]                 read_addr,
    output logic                                  stream_valid,
    output logic                                  busy,
    output logic                                  layer_done,
    output logic                                  layer_fail
);

    localparam int ROW_W = SYSTOLIC_SIZE * WEIGHT_WIDTH;
    localparam int CNT_W = $clog2(SYSTOLIC_SIZE + 1);

    localparam logic [CNT_W-1:0]      c_rows      = CNT_W'(SYSTOLIC_SIZE);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_row;
    logic                  r_alloc_start;
    logic [ROW_W-1:0]      r_weights;
    logic                  r_weight_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_stream_valid;
    logic                  r_layer_done;
    logic                  r_layer_fail;

    logic                  w_src_ready;
    logic                  w_accept;

`ifdef ALLOC_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] c_wd_last = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0]       r_wd;
`endif

    // Ready drops combinationally once the N-th row is counted, so the
    // final LOAD cycle (last alloc_weight_valid) never accepts a beat.
    assign w_src_ready = (r_state == ST_LOAD) && (r_row != c_rows);
    assign w_accept    = w_src_ready && src_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_row          <= '0;
            r_alloc_start  <= 1'b0;
            r_weights      <= '0;
            r_weight_valid <= 1'b0;
            r_addr         <= '0;
            r_stream_valid <= 1'b0;
            r_layer_done   <= 1'b0;
            r_layer_fail   <= 1'b0;
`ifdef ALLOC_WATCHDOG_EN
            r_wd           <= '0;
`endif
        end else begin
            r_weight_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (layer_start) begin
                        r_state       <= ST_START;
                        r_alloc_start <= 1'b1;
                    end
                end

                ST_START: begin
                    r_alloc_start <= 1'b0;
                    r_row         <= '0;
                    r_state       <= ST_LOAD;
                end

                ST_LOAD: begin
                    if (w_accept) begin
                        r_weights      <= src_weights;
                        r_weight_valid <= 1'b1;
                        r_row          <= r_row + CNT_W'(1);
                    end
                    if (r_row == c_rows) begin
                        r_state <= ST_WAIT;
`ifdef ALLOC_WATCHDOG_EN
                        r_wd    <= '0;
`endif
                    end
                end

                ST_WAIT: begin
                    if (recovery_done) begin
                        if (recovery_success) begin
                            r_state        <= ST_STREAM;
                            r_stream_valid <= 1'b1;
                            r_addr         <= '0;
                        end else begin
                            r_state      <= ST_FAIL;
                            r_layer_fail <= 1'b1;
                        end
                    end
`ifdef ALLOC_WATCHDOG_EN
                    // WAIT lasts at most TIMEOUT_CYCLES cycles before giving up.
                    else if (r_wd == c_wd_last) begin
                        r_state      <= ST_FAIL;
                        r_layer_fail <= 1'b1;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
`endif
                end

                ST_STREAM: begin
                    if (r_addr == c_last_addr) begin
                        r_stream_valid <= 1'b0;
                        r_addr         <= '0;
                        r_layer_done   <= 1'b1;
                        r_state        <= ST_DONE;
                    end else begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                end

                ST_DONE: begin
                    r_layer_done <= 1'b0;
                    r_row        <= '0;
                    r_state      <= ST_IDLE;
                end

                ST_FAIL: begin
                    r_layer_fail <= 1'b0;
                    r_row        <= '0;
                    r_state      <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign src_ready          = w_src_ready;
    assign alloc_start        = r_alloc_start;
    assign alloc_weights      = r_weights;
    assign alloc_weight_valid = r_weight_valid;
    assign read_addr          = r_addr;
    assign stream_valid       = r_stream_valid;
    assign busy               = (r_state != ST_IDLE);
    assign layer_done         = r_layer_done;
    assign layer_fail         = r_layer_fail;

endmodule

`default_nettype wire

// File: tb/tb_weight_alloc_sequencer.sv
// ============================================================================
// Module  : tb_weight_alloc_sequencer
// Purpose : Directed scoreboard bench for weight_alloc_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_weight_alloc_sequencer;

    localparam int N     = 8;
    localparam int W     = 8;
    localparam int AW    = $clog2(N);
    localparam int ROW_W = N * W;
    localparam int TO    = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             layer_start;
    logic             src_valid;
    logic             src_ready;
    logic [ROW_W-1:0] src_weights;
    logic             alloc_start;
    logic [ROW_W-1:0] alloc_weights;
    logic             alloc_weight_valid;
    logic             recovery_done;
    logic             recovery_success;
    logic [AW-1:0]    read_addr;
    logic             stream_valid;
    logic             busy;
    logic             layer_done;
    logic             layer_fail;

    weight_alloc_sequencer #(
        .SYSTOLIC_SIZE (N),
        .WEIGHT_WIDTH  (W),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .layer_start       (layer_start),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .src_weights       (src_weights),
        .alloc_start       (alloc_start),
        .alloc_weights     (alloc_weights),
        .alloc_weight_valid(alloc_weight_valid),
        .recovery_done     (recovery_done),
        .recovery_success  (recovery_success),
        .read_addr         (read_addr),
        .stream_valid      (stream_valid),
        .busy              (busy),
        .layer_done        (layer_done),
        .layer_fail        (layer_fail)
    );

    always #5 clk = ~clk;

    int               errors = 0;
    int               checks = 0;
    int               cyc    = 0;
    int               n_acc  = 0;
    int               first_awv;
    int               last_awv;
    bit               seen_awv = 1'b0;
    logic [ROW_W-1:0] last_row = '0;
    logic [ROW_W-1:0] row_q[$];
    int               addr_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records accepted beats into the scoreboard, then advances one cycle.
    task automatic tick();
        if (src_valid && src_ready) begin
            row_q.push_back(src_weights);
            last_row = src_weights;
            n_acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (alloc_weight_valid) begin
                if (!seen_awv) first_awv = cyc;
                seen_awv = 1'b1;
                last_awv = cyc;
                if (row_q.size() == 0) chk("awv_spurious", alloc_weight_valid, 0);
                else                   chk("alloc_weights", alloc_weights, row_q.pop_front());
            end
            if (stream_valid) begin
                if (addr_q.size() == 0) chk("stream_spurious", stream_valid, 0);
                else                    chk("read_addr", read_addr, addr_q.pop_front());
            end else begin
                chk("read_addr_idle", read_addr, 0);
            end
        end
    end

    task automatic do_start();
        layer_start = 1'b1;
        cyc = 0;
        tick();
        layer_start = 1'b0;
        chk("alloc_start", alloc_start, 1);
        chk("busy_start", busy, 1);
    endtask

    task automatic load(input bit toggle, input bit early, input bit mid, input bit fixed);
        int i;
        n_acc = 0;
        i = 0;
        while (n_acc < N && i < 60) begin
            src_valid     = toggle ? (i % 2 == 0) : 1'b1;
            recovery_done = early;
            layer_start   = mid && (i == 4);
            if (fixed) begin
                for (int k = 0; k < N; k++) src_weights[k*W +: W] = W'(n_acc + 1);
            end else begin
                src_weights = {$urandom(), $urandom()};
            end
            tick();
            if (i == 0) chk("alloc_start_one_cycle", alloc_start, 0);
            if (!rst_n) break;
            i++;
        end
        layer_start = 1'b0;
        chk("load_beats", n_acc, N);
        chk("src_ready_after_last", src_ready, 0);
        chk("stream_during_load", stream_valid, 0);
        src_valid = 1'b1;
        tick();
        src_valid     = 1'b0;
        recovery_done = 1'b0;
        chk("no_extra_beat", alloc_weight_valid, 0);
        chk("alloc_weights_hold", alloc_weights, last_row);
        chk("busy_wait", busy, 1);
    endtask

    task automatic finish(input bit ok, input bit mid);
        int n;
        recovery_done    = 1'b1;
        recovery_success = ok;
        if (ok) for (int a = 0; a < N; a++) addr_q.push_back(a);
        tick();
        recovery_done    = 1'b0;
        recovery_success = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (layer_done || layer_fail) break;
            layer_start = mid && (i == 3);
            tick();
            n++;
        end
        layer_start = 1'b0;
        chk("layer_done", layer_done, ok);
        chk("layer_fail", layer_fail, !ok);
        chk("resp_latency", n, ok ? N : 0);
        tick();
        chk("done_pulse", layer_done, 0);
        chk("fail_pulse", layer_fail, 0);
        chk("busy_after", busy, 0);
        chk("stream_drained", addr_q.size(), 0);
    endtask

    initial begin
        rst_n            = 1'b0;
        layer_start      = 1'b0;
        src_valid        = 1'b0;
        src_weights      = '0;
        recovery_done    = 1'b0;
        recovery_success = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_alloc_weights", alloc_weights, 0);
        chk("rst_stream_valid", stream_valid, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Back-to-back rows 1..8: timing of alloc_start / alloc_weight_valid.
        seen_awv = 1'b0;
        do_start();
        chk("alloc_start_cycle", cyc, 1);
        load(1'b0, 1'b0, 1'b0, 1'b1);
        chk("first_awv_cycle", first_awv, 3);
        chk("last_awv_cycle", last_awv, 10);
        chk("wait_entry_cycle", cyc, 11);
        finish(1'b1, 1'b0);

        // Gapped source, early recovery_done, stray layer_start in LOAD/STREAM.
        do_start();
        load(1'b1, 1'b1, 1'b1, 1'b0);
        finish(1'b1, 1'b1);

        // Recovery failure.
        do_start();
        load(1'b0, 1'b0, 1'b0, 1'b0);
        finish(1'b0, 1'b0);

        // Asynchronous reset mid-LOAD.
        do_start();
        n_acc     = 0;
        src_valid = 1'b1;
        for (int i = 0; i < 20 && n_acc < 4; i++) begin
            src_weights = {$urandom(), $urandom()};
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_src_ready", src_ready, 0);
        chk("arst_awv", alloc_weight_valid, 0);
        chk("arst_alloc_weights", alloc_weights, 0);
        chk("arst_alloc_start", alloc_start, 0);
        row_q.delete();
        src_valid = 1'b0;
        tick();
        rst_n     = 1'b1;
        src_valid = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", busy, 0);
        chk("post_rst_no_ready", src_ready, 0);
        src_valid = 1'b0;
        do_start();
        load(1'b0, 1'b0, 1'b0, 1'b0);
        finish(1'b1, 1'b0);

        // WAIT with recovery_done held low.
        do_start();
        load(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ALLOC_WATCHDOG_EN
        begin
            int k;
            k = 1;
            for (int i = 0; i < 60; i++) begin
                if (layer_fail) break;
                tick();
                k++;
            end
            chk("watchdog_cycle", k, TO + 1);
            tick();
            chk("watchdog_busy", busy, 0);
        end
`else
        repeat (101) tick();
        chk("wait_indefinite", busy, 1);
        chk("wait_no_fail", layer_fail, 0);
        finish(1'b0, 1'b0);
`endif

        chk("scoreboard_empty", row_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
